// File: rtl/sb_drain_unit_pkg.sv
// Shared widths, FSM state encoding and sizing helpers for the store-buffer drain unit.
package sb_drain_unit_pkg;

  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_WIDTH = 32;
  localparam int SB_WIDTH      = SB_ADDR_WIDTH + SB_DATA_WIDTH;
  localparam int TIMEOUT_DEF   = 64;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_WRITE   = 2'd2,
    ST_MEM_REQ = 2'd3
  } drain_state_t;

  // Wait counter must be able to hold the value TIMEOUT itself.
  function automatic int wait_cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/sb_drain_unit_if.sv
// Drain-side, D-cache and memory write buses of the drain unit.
interface sb_drain_unit_if
  import sb_drain_unit_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_WIDTH,
  parameter int DATA_W = SB_DATA_WIDTH
);

  logic [ADDR_W+DATA_W-1:0] data_to_cache;
  logic                     sending_data_to_cache;
  logic                     sb_ack;

  logic                     lookup_valid;
  logic [ADDR_W-1:0]        lookup_addr;
  logic                     cache_hit;
  logic                     cache_wr_en;
  logic [ADDR_W-1:0]        cache_wr_addr;
  logic [DATA_W-1:0]        cache_wr_data;

  logic                     mem_wr_req;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_data;
  logic                     mem_ack;

  // Drain unit side.
  modport slave (
    input  data_to_cache, sending_data_to_cache, cache_hit, mem_ack,
    output sb_ack, lookup_valid, lookup_addr,
           cache_wr_en, cache_wr_addr, cache_wr_data,
           mem_wr_req, mem_addr, mem_data
  );

  // Store buffer / cache / memory side.
  modport master (
    output data_to_cache, sending_data_to_cache, cache_hit, mem_ack,
    input  sb_ack, lookup_valid, lookup_addr,
           cache_wr_en, cache_wr_addr, cache_wr_data,
           mem_wr_req, mem_addr, mem_data
  );

endinterface

// File: rtl/sb_drain_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; flags the cycle in which LIMIT cycles have elapsed.
module sb_drain_unit_sat_counter #(
  parameter int W     = 7,
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + W'(1);
    end
  end

  // count holds the cycles already waited, so the current cycle is number count+1.
  assign at_limit = (count >= CNT_LAST);

endmodule

// File: rtl/sb_drain_unit.sv
// Store-buffer drain consumer: cache write on hit, write-no-allocate to memory on miss.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for the store buffer to present an entry
// ST_LOOKUP  | tag lookup of the held address, hit sampled at cycle end
// ST_WRITE   | one-cycle D-cache write of the held entry
// ST_MEM_REQ | memory write held until ack or timeout
module sb_drain_unit
  import sb_drain_unit_pkg::*;
#(
  parameter int ADDR_W  = SB_ADDR_WIDTH,
  parameter int DATA_W  = SB_DATA_WIDTH,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  sb_drain_unit_if.slave    bus,
  output logic              drain_busy,
  output logic              drain_err,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int WAIT_W = wait_cnt_w(TIMEOUT);

  drain_state_t      state_q, state_d;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              sb_ack_q;

  logic load;
  logic wait_clr;
  logic hit_inc;
  logic miss_inc;
  logic err_set;
  logic wait_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    wait_clr = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.sending_data_to_cache) begin
          load    = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (bus.cache_hit) begin
          state_d = ST_WRITE;
        end else begin
          wait_clr = 1'b1;
          state_d  = ST_MEM_REQ;
        end
      end
      ST_WRITE: begin
        hit_inc = 1'b1;
        state_d = ST_IDLE;
      end
      ST_MEM_REQ: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (bus.mem_ack) begin
          miss_inc = 1'b1;
          state_d  = ST_IDLE;
        end else if (wait_done) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sb_drain_unit_sat_counter #(
    .W     (WAIT_W),
    .LIMIT (TIMEOUT)
  ) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (wait_clr),
    .en       (state_q == ST_MEM_REQ),
    .at_limit (wait_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_addr <= '0;
      hold_data <= '0;
      sb_ack_q  <= 1'b0;
    end else begin
      sb_ack_q <= load;
      if (load) begin
        hold_addr <= bus.data_to_cache[ADDR_W+DATA_W-1:DATA_W];
        hold_data <= bus.data_to_cache[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      drain_err  <= 1'b0;
    end else begin
      if (hit_inc) begin
        hit_count <= hit_count + CNT_W'(1);
      end
      if (miss_inc) begin
        miss_count <= miss_count + CNT_W'(1);
      end
      if (err_set) begin
        drain_err <= 1'b1;
      end
    end
  end

  // Bus outputs decode from the state register; addresses/data read zero when not strobed.
  assign drain_busy        = (state_q != ST_IDLE);
  assign bus.sb_ack        = sb_ack_q;
  assign bus.lookup_valid  = (state_q == ST_LOOKUP);
  assign bus.lookup_addr   = bus.lookup_valid ? hold_addr : '0;
  assign bus.cache_wr_en   = (state_q == ST_WRITE);
  assign bus.cache_wr_addr = bus.cache_wr_en ? hold_addr : '0;
  assign bus.cache_wr_data = bus.cache_wr_en ? hold_data : '0;
  assign bus.mem_wr_req    = (state_q == ST_MEM_REQ);
  assign bus.mem_addr      = bus.mem_wr_req ? hold_addr : '0;
  assign bus.mem_data      = bus.mem_wr_req ? hold_data : '0;

endmodule
